// File: rtl/layer_stream_pkg.sv
// layer_stream_pkg
// Shared definitions for the layer pixel stream blocks: default channel word
// width and channel count, the frame-buffer read latency, the sequencer state
// type and a counter-width helper.
package layer_stream_pkg;

  localparam int LS_DATA_WIDTH  = 32;
  localparam int LS_NUM_CH      = 3;
  // Cycles from mem_rd_en to mem_rd_data being valid.
  localparam int MEM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen
// Channel/pixel read sequencer for a planar, channel-major frame.
// Walks ch = 0..NUM_CH-1 fastest, pix = 0..IMG_SIZE^2-1 slowest, and forms
// addr = BASE_ADDR + ch*IMG_SIZE^2 + pix (mod 2^ADDR_WIDTH).
// Ports:
//   Clk, Rst  - clock, async active-low reset
//   en        - advance to the next channel read
//   ch        - current channel index
//   addr      - word address of the current (ch, pix)
//   last      - current read is channel NUM_CH-1 of the final pixel
module pixel_addr_gen
  import layer_stream_pkg::*;
#(
  parameter int NUM_CH     = LS_NUM_CH,
  parameter int IMG_SIZE   = 416,
  parameter int ADDR_WIDTH = 20,
  parameter int BASE_ADDR  = 0,
  parameter int CH_W       = cnt_width(NUM_CH)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  en,
  output logic [CH_W-1:0]       ch,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int NUM_PIX = IMG_SIZE * IMG_SIZE;
  localparam int PIX_W   = cnt_width(NUM_PIX);

  localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0]      PIX_LAST = PIX_W'(NUM_PIX - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(NUM_PIX);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  logic [PIX_W-1:0]      pix;
  // Running ch*IMG_SIZE^2, kept incrementally so no multiplier is needed.
  logic [ADDR_WIDTH-1:0] plane_off;

  assign last = (ch == CH_LAST) && (pix == PIX_LAST);
  assign addr = BASE + plane_off + ADDR_WIDTH'(pix);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ch        <= '0;
      pix       <= '0;
      plane_off <= '0;
    end else if (en) begin
      if (ch == CH_LAST) begin
        ch        <= '0;
        plane_off <= '0;
        pix       <= (pix == PIX_LAST) ? '0 : pix + 1'b1;
      end else begin
        ch        <= ch + 1'b1;
        plane_off <= plane_off + STRIDE;
      end
    end
  end

endmodule

// File: rtl/layer_input_streamer.sv
// layer_input_streamer
// Reads a planar channel-major IMG_SIZE x IMG_SIZE frame from word-addressed
// memory and streams one packed NUM_CH-channel pixel per beat in raster order.
// Ports:
//   Clk, Rst     - clock, async active-low reset
//   start        - one-cycle frame request (ignored while busy)
//   mem_rd_en    - memory read strobe
//   mem_rd_addr  - memory word address (0 when not reading)
//   mem_rd_data  - read data, valid MEM_RD_LATENCY cycles after mem_rd_en
//   data_out     - packed pixel, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_out    - one-cycle pulse per pixel
//   busy         - frame in progress
//   done         - pulse with the last pixel's valid_out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_READ  | issuing one channel read per cycle
// ST_DRAIN | all reads issued, waiting for the final pixel to emerge
module layer_input_streamer
  import layer_stream_pkg::*;
#(
  parameter int DATA_WIDTH = LS_DATA_WIDTH,
  parameter int NUM_CH     = LS_NUM_CH,
  parameter int IMG_SIZE   = 416,
  parameter int ADDR_WIDTH = 20,
  parameter int BASE_ADDR  = 0
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         start,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic                         busy,
  output logic                         done
);

  localparam int              CH_W    = cnt_width(NUM_CH);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  stream_state_e state, state_nxt;

  logic [CH_W-1:0]       ch;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last;

  // Read-latency pipeline: the channel tag travels alongside the strobe.
  logic                  en_pipe [MEM_RD_LATENCY];
  logic [CH_W-1:0]       ch_pipe [MEM_RD_LATENCY];
  logic                  rd_ret;
  logic [CH_W-1:0]       ch_ret;

  logic [DATA_WIDTH-1:0]        slot [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0] pixel_full;

  pixel_addr_gen #(
    .NUM_CH     (NUM_CH),
    .IMG_SIZE   (IMG_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .CH_W       (CH_W)
  ) u_addr_gen (
    .Clk  (Clk),
    .Rst  (Rst),
    .en   (mem_rd_en),
    .ch   (ch),
    .addr (addr),
    .last (last)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ: begin
        mem_rd_en = 1'b1;
        if (last) state_nxt = ST_DRAIN;
      end
      // No pixel is in flight besides the final one once in DRAIN.
      ST_DRAIN: if (valid_out) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign mem_rd_addr = mem_rd_en ? addr : '0;
  assign busy        = (state != ST_IDLE);
  assign done        = valid_out && (state == ST_DRAIN);

  assign rd_ret = en_pipe[MEM_RD_LATENCY-1];
  assign ch_ret = ch_pipe[MEM_RD_LATENCY-1];

  // Top slot bypasses the assembly register so the pixel is complete in the
  // same cycle its final channel returns.
  always_comb begin
    pixel_full = '0;
    for (int k = 0; k < NUM_CH - 1; k++)
      pixel_full[k*DATA_WIDTH +: DATA_WIDTH] = slot[k];
    pixel_full[(NUM_CH-1)*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < MEM_RD_LATENCY; i++) begin
        en_pipe[i] <= 1'b0;
        ch_pipe[i] <= '0;
      end
      for (int k = 0; k < NUM_CH; k++) slot[k] <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      en_pipe[0] <= mem_rd_en;
      ch_pipe[0] <= ch;
      for (int i = 1; i < MEM_RD_LATENCY; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        ch_pipe[i] <= ch_pipe[i-1];
      end
      valid_out <= 1'b0;
      if (rd_ret) begin
        slot[ch_ret] <= mem_rd_data;
        if (ch_ret == CH_LAST) begin
          data_out  <= pixel_full;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_input_streamer.sv
// tb_layer_input_streamer
// Two streamers (BASE_ADDR 0 and 100) run in lockstep on a shared 256-word
// memory. Each cycle every output is compared with a frame-level reference
// computed from pixel/channel indices and the memory contents.
module tb_layer_input_streamer;

  localparam int N   = 16;          // IMG_SIZE^2 for IMG_SIZE = 4
  localparam int NCH = 3;
  localparam int BA  = 0;
  localparam int BB  = 100;
  localparam int LAST_T = NCH * N + 2;

  logic        Clk, Rst, start;
  logic        en_a, en_b, val_a, val_b, busy_a, busy_b, done_a, done_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] rd_a, rd_b;
  logic [95:0] dout_a, dout_b;

  logic [31:0] mem [256];
  logic [95:0] exp_a, exp_b;
  logic [95:0] cap_a [N];
  logic [95:0] cap_b [N];

  int n_vec = 0;
  int n_bad = 0;

  layer_input_streamer #(
    .DATA_WIDTH(32), .NUM_CH(NCH), .IMG_SIZE(4), .ADDR_WIDTH(8), .BASE_ADDR(BA)
  ) dut_a (
    .Clk(Clk), .Rst(Rst), .start(start),
    .mem_rd_en(en_a), .mem_rd_addr(addr_a), .mem_rd_data(rd_a),
    .data_out(dout_a), .valid_out(val_a), .busy(busy_a), .done(done_a)
  );

  layer_input_streamer #(
    .DATA_WIDTH(32), .NUM_CH(NCH), .IMG_SIZE(4), .ADDR_WIDTH(8), .BASE_ADDR(BB)
  ) dut_b (
    .Clk(Clk), .Rst(Rst), .start(start),
    .mem_rd_en(en_b), .mem_rd_addr(addr_b), .mem_rd_data(rd_b),
    .data_out(dout_b), .valid_out(val_b), .busy(busy_b), .done(done_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One-cycle read latency memory.
  always @(posedge Clk) begin
    rd_a <= mem[addr_a];
    rd_b <= mem[addr_b];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [95:0] model_pix(input int base, input int p);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[k*32 +: 32] = mem[(base + k*N + p) % 256];
    return r;
  endfunction

  // t = cycle index relative to the accepted start; t < 0 means idle.
  task automatic check_dut(input string pfx, input int t, input int base,
                           input logic en, input logic [7:0] addr, input logic val,
                           input logic [95:0] dout, input logic bsy, input logic dn,
                           inout logic [95:0] exp_d);
    bit e_en, e_val;
    int idx, ea;
    idx   = t - 1;
    e_en  = (t >= 1) && (t <= NCH * N);
    ea    = e_en ? (base + (idx % NCH) * N + idx / NCH) % 256 : 0;
    e_val = (t >= 5) && ((t - 5) % NCH == 0) && ((t - 5) / NCH < N);
    if (e_val) exp_d = model_pix(base, (t - 5) / NCH);
    chk({pfx, "_rd_en"}, en, e_en);
    chk({pfx, "_rd_addr"}, addr, ea);
    chk({pfx, "_valid"}, val, e_val);
    chk({pfx, "_data"}, dout, exp_d);
    chk({pfx, "_busy"}, bsy, (t >= 1) && (t <= LAST_T));
    chk({pfx, "_done"}, dn, t == LAST_T);
  endtask

  task automatic check_reset_state();
    chk("rst_a_en", en_a, 1'b0);   chk("rst_b_en", en_b, 1'b0);
    chk("rst_a_addr", addr_a, 0);  chk("rst_b_addr", addr_b, 0);
    chk("rst_a_valid", val_a, 1'b0); chk("rst_b_valid", val_b, 1'b0);
    chk("rst_a_busy", busy_a, 1'b0); chk("rst_b_busy", busy_b, 1'b0);
    chk("rst_a_done", done_a, 1'b0); chk("rst_b_done", done_b, 1'b0);
    chk("rst_a_data", dout_a, 0);  chk("rst_b_data", dout_b, 0);
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < n; g++) begin
      start = 1'b0;
      check_dut("idle_a", -1, BA, en_a, addr_a, val_a, dout_a, busy_a, done_a, exp_a);
      check_dut("idle_b", -1, BB, en_b, addr_b, val_b, dout_b, busy_b, done_b, exp_b);
      @(posedge Clk); #1;
    end
  endtask

  // Runs one frame from its cycle 0; ign_at re-pulses start mid-frame,
  // abort_at drops Rst in that cycle and abandons the frame.
  task automatic run_frame(input int ign_at, input int abort_at);
    for (int t = 0; t <= LAST_T; t++) begin
      start = (t == 0) || (t == ign_at);
      if (t == abort_at) begin
        start = 1'b0;
        #2 Rst = 1'b0;
        #1;
        check_reset_state();
        exp_a = '0;
        exp_b = '0;
        repeat (2) @(posedge Clk);
        #3 Rst = 1'b1;
        @(posedge Clk); #1;
        return;
      end
      check_dut("a", t, BA, en_a, addr_a, val_a, dout_a, busy_a, done_a, exp_a);
      check_dut("b", t, BB, en_b, addr_b, val_b, dout_b, busy_b, done_b, exp_b);
      if (val_a && t >= 5) cap_a[((t - 5) / NCH) % N] = dout_a;
      if (val_b && t >= 5) cap_b[((t - 5) / NCH) % N] = dout_b;
      @(posedge Clk); #1;
    end
    start = 1'b0;
  endtask

  logic [95:0] k_pix5, k_base0;

  initial begin
    Rst   = 1'b0;
    start = 1'b0;
    exp_a = '0;
    exp_b = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    for (int i = 0; i < N; i++) begin cap_a[i] = '0; cap_b[i] = '0; end
    k_pix5  = {32'd37, 32'd21, 32'd5};
    k_base0 = {32'd132, 32'd116, 32'd100};

    repeat (2) @(posedge Clk); #1;
    check_reset_state();
    Rst = 1'b1;
    @(posedge Clk); #1;
    idle(1);

    // Basic frame, then a back-to-back frame in the cycle after done.
    run_frame(-1, -1);
    chk("pix5_const", cap_a[5], k_pix5);
    chk("base100_pix0", cap_b[0], k_base0);
    run_frame(-1, -1);
    chk("b2b_pix5_const", cap_a[5], k_pix5);
    idle(2);

    // start while busy is ignored.
    run_frame(20, -1);
    idle(1);

    // Reset mid-frame, then a fresh frame with no stale pixel.
    run_frame(-1, 30);
    run_frame(-1, -1);
    idle(1);

    // Random memory contents, gaps, spurious starts and aborts.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int f = 0; f < 8; f++) begin
      int ign, ab;
      idle($urandom_range(0, 3));
      ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAST_T)) : -1;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAST_T)) : -1;
      run_frame(ign, ab);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_input_streamer.md
# layer_input_streamer

Transmit side of the layer pixel stream. The block reads a planar, channel-major image from a word-addressed memory and emits one packed multi-channel pixel per beat in raster order on a `data_out`/`valid_out` stream. This is the stream format consumed by the `layer_N_featuremap_M` blocks. It sits between the frame buffer and layer 0 and paces a whole IMG_SIZE×IMG_SIZE frame per `start` pulse.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one channel word (IEEE-754 single).
- `NUM_CH`, 3: channels per pixel.
- `IMG_SIZE`, 416: frame width and height, in pixels.
- `ADDR_WIDTH`, 20: memory word-address width. Must satisfy NUM_CH·IMG_SIZE² ≤ 2^ADDR_WIDTH.
- `BASE_ADDR`, 0: word address of channel 0, pixel 0.

Ports:
- `Clk`, in, 1: single clock; all logic is on the rising edge.
- `Rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle frame request.
- `mem_rd_en`, out, 1: memory read strobe.
- `mem_rd_addr`, out, ADDR_WIDTH: read word address.
- `mem_rd_data`, in, DATA_WIDTH: read data. Valid exactly one cycle after `mem_rd_en`.
- `data_out`, out, NUM_CH·DATA_WIDTH: packed pixel. Channel k occupies bits [k·DATA_WIDTH +: DATA_WIDTH].
- `valid_out`, out, 1: one-cycle pulse marking a valid pixel.
- `busy`, out, 1: a frame is in progress.
- `done`, out, 1: one-cycle pulse coincident with the last pixel's `valid_out`.

## Operation
- FSM states: IDLE, READ, DRAIN.
  - IDLE → READ when `start`=1.
  - READ → DRAIN after the read for channel NUM_CH−1 of pixel IMG_SIZE²−1 is issued.
  - DRAIN → IDLE once that pixel is emitted.
- Counters:
  - Channel counter `ch`: 0..NUM_CH−1.
  - Pixel counter `pix`: 0..IMG_SIZE²−1.
  - `ch` wraps to 0 and `pix` increments together.
- Read address: BASE_ADDR + ch·IMG_SIZE² + pix, computed modulo 2^ADDR_WIDTH.
- Read issue: in READ, `mem_rd_en`=1 every cycle, one channel read per cycle, channel 0 first.
- Data capture:
  - A delayed copy of `mem_rd_en`/`ch` steers the returning `mem_rd_data` into channel slot `ch` of an assembly register.
  - When slot NUM_CH−1 is captured, the full pixel (slot NUM_CH−1 taken directly from `mem_rd_data`) is registered into `data_out`, and `valid_out` pulses on the following cycle.
- `data_out` holds its last value between pulses.
- No backpressure: the downstream consumer must accept every beat.
- `start` while `busy`=1 is ignored; the frame in progress is not disturbed.
- `Rst` low at any time:
  - State → IDLE; all counters → 0.
  - `mem_rd_en`, `valid_out`, `busy`, `done` → 0; `mem_rd_addr` → 0; `data_out` → 0.
  - A partial frame is abandoned. It is not resumed after reset releases.

## Timing
Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Read issue: the read for channel k of pixel p is issued in cycle 3p+k+1 (general form NUM_CH·p+k+1).
- `busy`: high from cycle 1 through the last `valid_out` cycle inclusive.
- `valid_out`: for pixel p it is high in cycle NUM_CH·p+NUM_CH+2. That is cycle 5 for pixel 0 at NUM_CH=3, then one pulse every NUM_CH cycles.
- Latency: start to first pixel is 5 cycles; last read to its `valid_out` is 2 cycles.
- End of frame (N = IMG_SIZE²):
  - Last `valid_out` is in cycle NUM_CH·N+2.
  - `done` is high in the same cycle.
  - `busy` falls, and IDLE is re-entered, on the following edge.
- Back-to-back frames: a `start` in the cycle after `done` begins a new frame with identical timing.

## Structure
- Shared package `layer_stream_pkg`:
  - `DATA_WIDTH` and `NUM_CH` defaults.
  - Memory read-latency constant (1).
  - FSM state typedef.
- Sub-module `pixel_addr_gen`: the `ch`/`pix` counters, wrap logic and address adder, with a `last` flag.
- The top level holds the FSM, the read-latency pipeline, pixel assembly and the output registers.

## Test plan
All scenarios use IMG_SIZE=4 and NUM_CH=3; the memory model returns `mem_rd_data` = address.
- Basic frame: `start` in cycle 0 → `valid_out` pulses in cycles 5, 8, …, 50. Pixel 5 gives `data_out` = {32'd37, 32'd21, 32'd5}. `done` is high only in cycle 50.
- Address sequence: check `mem_rd_addr` in cycles 1..48 = 0, 16, 32, 1, 17, 33, … ending with 47. `mem_rd_en` is low in cycles 0 and 49.
- `start` re-asserted in cycle 20 → ignored; output timing is identical to the basic frame.
- `Rst` low in cycle 30 → all outputs are 0 immediately. A `start` after release → fresh frame beginning at address 0; no stale pixel appears.
- BASE_ADDR=100 → pixel 0 is {32'd132, 32'd116, 32'd100}.
- Back-to-back: `start` in cycle 51 → second frame's first `valid_out` in cycle 56, with content identical to the first frame.
